// File: rtl/dma_addr_gen_pkg.sv
// rtl/dma_addr_gen_pkg.sv - shared types and constants for the DMA address generator
package dma_addr_gen_pkg;

   localparam int ACR_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_CYCLE = 3'd2,
      ST_TERM  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // active-low dynamic-size acknowledge encodings
   localparam logic [1:0] DSACK_32   = 2'b00;
   localparam logic [1:0] DSACK_16   = 2'b01;
   localparam logic [1:0] DSACK_8    = 2'b10;
   localparam logic [1:0] DSACK_NONE = 2'b11;

   // address increment per completed transfer, in bytes
   localparam logic [2:0] INC_LONG = 3'd4;
   localparam logic [2:0] INC_WORD = 3'd2;
   localparam logic [2:0] INC_BYTE = 3'd1;

endpackage

// File: rtl/dma_term_decode.sv
// rtl/dma_term_decode.sv - combinational decode of bus termination inputs
module dma_term_decode
   import dma_addr_gen_pkg::*;
(
   input  logic       sterm_n,
   input  logic [1:0] dsack_n,
   input  logic       berr_n,
   output logic       term,
   output logic       err,
   output logic [2:0] inc
);

   // error outranks termination; _STERM is always a 32-bit transfer
   always_comb begin
      err  = ~berr_n;
      term = ~sterm_n | (dsack_n != DSACK_NONE);
      inc  = INC_LONG;
      if (sterm_n) begin
         case (dsack_n)
            DSACK_16: inc = INC_WORD;
            DSACK_8:  inc = INC_BYTE;
            default:  inc = INC_LONG;
         endcase
      end
   end

endmodule

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - DMA address counter and bus-cycle tracking FSM
module dma_addr_gen
   import dma_addr_gen_pkg::*;
(
   input  logic             SCLK,
   input  logic             RST,
   input  logic             ACR_WR,
   input  logic [ACR_W-1:0] ACR_DIN,
   input  logic             _DMAEN,
   input  logic             _AS,
   input  logic             _STERM,
   input  logic [1:0]       _DSACK,
   input  logic             _BERR,
   output logic [ACR_W-1:0] ADDR_O,
   output logic             ADDR_OE,
   output logic             CYC_DONE,
   output logic             BERR_FLAG,
   output logic [2:0]       STATE_O
);

   state_t           state;
   logic [ACR_W-1:0] acr;
   logic [2:0]       inc_lat;
   logic             addr_oe;
   logic             cyc_done;
   logic             berr_flag;

   logic             dec_term;
   logic             dec_err;
   logic [2:0]       dec_inc;

   dma_term_decode u_term_decode (
      .sterm_n (_STERM),
      .dsack_n (_DSACK),
      .berr_n  (_BERR),
      .term    (dec_term),
      .err     (dec_err),
      .inc     (dec_inc)
   );

   // FSM, address counter and registered status outputs
   always_ff @(posedge SCLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         acr       <= '0;
         inc_lat   <= INC_LONG;
         addr_oe   <= 1'b0;
         cyc_done  <= 1'b0;
         berr_flag <= 1'b0;
      end else begin
         cyc_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ACR_WR) begin
                  acr       <= ACR_DIN;
                  berr_flag <= 1'b0;
               end
               if (!_DMAEN) begin
                  state   <= ST_ARMED;
                  addr_oe <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (ACR_WR) begin
                  acr       <= ACR_DIN;
                  berr_flag <= 1'b0;
               end
               if (_DMAEN) begin
                  state   <= ST_IDLE;
                  addr_oe <= 1'b0;
               end else if (!_AS) begin
                  state <= ST_CYCLE;
               end
            end
            ST_CYCLE: begin
               // a bus error on the terminating edge discards the increment
               if (dec_err) begin
                  state     <= ST_ERR;
                  berr_flag <= 1'b1;
               end else if (dec_term) begin
                  state   <= ST_TERM;
                  inc_lat <= dec_inc;
               end
            end
            ST_TERM: begin
               if (_AS) begin
                  acr      <= acr + {{(ACR_W-3){1'b0}}, inc_lat};
                  cyc_done <= 1'b1;
                  state    <= _DMAEN ? ST_IDLE : ST_ARMED;
                  addr_oe  <= ~_DMAEN;
               end
            end
            ST_ERR: begin
               if (_AS) begin
                  state   <= _DMAEN ? ST_IDLE : ST_ARMED;
                  addr_oe <= ~_DMAEN;
               end
            end
            default: begin
               state   <= ST_IDLE;
               addr_oe <= 1'b0;
            end
         endcase
      end
   end

   assign ADDR_O    = acr;
   assign ADDR_OE   = addr_oe;
   assign CYC_DONE  = cyc_done;
   assign BERR_FLAG = berr_flag;
   assign STATE_O   = state;

endmodule
